count_event_logger: RTL and testbench

//   Downstream consumer of the up/down counter. Samples the counter's count
//   and direction every clk and detects wrap-around and threshold crossings.

---
 rtl/count_event_logger.sv | 106 ++++++++++
 tb/tb_count_event_logger.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/count_event_logger.sv
// count_event_logger
//   Watches an up/down counter (count + direction) every clock. It flags
//   wrap-up (MAX->0 counting up), wrap-down (0->MAX counting down) and
//   threshold arrival (count reaches thresh from another value). Each event
//   becomes one timestamped record in a show-ahead FIFO, and a consumer
//   drains that FIFO over valid/ready.
//
//   Optional feature: define EVT_DROP_CNT_EN to add the drop_cnt port, a
//   saturating count of records dropped because the FIFO was full.
//
// Ports
//   clk, reset  rising-edge clock, async active-high reset
//   counter     counter direction (1=up, 0=down)
//   count       counter value
//   thresh      threshold compare value (quasi-static)
//   evt_valid   FIFO head holds a record
//   evt_ready   consumer takes the head this cycle
//   evt_data    {ts[7:0], count, thr, wrap_dn, wrap_up}; zero when empty
//   evt_level   FIFO occupancy, 0..DEPTH
//   overflow    sticky: a record was dropped
//   drop_cnt    dropped-record count, saturates at 255 (EVT_DROP_CNT_EN only)
module count_event_logger #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       counter,
  input  logic [WIDTH-1:0]           count,
  input  logic [WIDTH-1:0]           thresh,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [WIDTH+10:0]          evt_data,
  output logic [$clog2(DEPTH+1)-1:0] evt_level,
  output logic                       overflow
`ifdef EVT_DROP_CNT_EN
  ,
  output logic [7:0]                 drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  logic [7:0]        ts;
  logic [WIDTH-1:0]  prev;
  logic              prev_vld;
  logic [WIDTH+10:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;

  logic wrap_up, wrap_dn, thr, push, pop, full, accept, drop;
  logic [WIDTH+10:0] rec;

  always_comb begin
    wrap_up = counter & (prev == MAX) & (count == '0);
    wrap_dn = ~counter & (prev == '0) & (count == MAX);
    thr     = (count == thresh) & (prev != thresh);
    push    = prev_vld & (wrap_up | wrap_dn | thr);
    rec     = {ts, count, thr, wrap_dn, wrap_up};
    full    = (level == LW'(DEPTH));
    pop     = evt_valid & evt_ready;
    // A full FIFO still takes a record when the head leaves on the same edge.
    accept  = push & (~full | pop);
    drop    = push & ~accept;
  end

  assign evt_valid = (level != '0);
  // Gate the head so evt_data reads zero when empty; the RAM itself is unreset.
  assign evt_data  = evt_valid ? mem[rd_ptr] : '0;
  assign evt_level = level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts       <= '0;
      prev     <= '0;
      prev_vld <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      ts       <= ts + 8'd1;
      prev     <= count;
      prev_vld <= 1'b1;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept & ~pop)      level <= level + 1'b1;
      else if (~accept & pop) level <= level - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= rec;
  end

`ifdef EVT_DROP_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       drop_cnt <= '0;
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_count_event_logger.sv
module tb_count_event_logger;
  logic        clk = 1'b0;
  logic        reset, counter, evt_ready, evt_valid, overflow;
  logic [3:0]  count, thresh;
  logic [14:0] evt_data;
  logic [3:0]  evt_level;
`ifdef EVT_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  count_event_logger #(.WIDTH(4), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .counter(counter), .count(count),
    .thresh(thresh), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_data(evt_data), .evt_level(evt_level), .overflow(overflow)
`ifdef EVT_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  cyc;       // model of the timestamp counter
  logic [14:0] q[$];      // records seen leaving the FIFO
  logic [14:0] ets[$];    // expected records
  logic [7:0]  d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive count, note a record the consumer is taking, advance.
  task automatic step(input logic [3:0] c);
    count = c;
    if (evt_valid && evt_ready) q.push_back(evt_data);
    @(posedge clk); #1;
    cyc = cyc + 8'd1;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    cyc   = 8'd0;
  endtask

  initial begin
    reset = 1'b1; counter = 1'b1; count = '0; thresh = 4'd5; evt_ready = 1'b1;
    cyc = '0;
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_level", evt_level, 0);
    chk("rst_ovf",   overflow,  0);
    chk("rst_data",  evt_data,  0);
`ifdef EVT_DROP_CNT_EN
    chk("rst_drop",  drop_cnt,  0);
`endif
    release_reset();

    // Count up 0..15,0 with thresh=5: threshold record then wrap-up record.
    for (int c = 0; c <= 4; c++) step(4'(c));
    chk("t2_no_evt_yet", evt_valid, 0);
    step(4'd5);
    chk("t2_thr_latency", evt_valid, 1);
    chk("t2_thr_data", evt_data, {8'd5, 4'd5, 3'b100});
    for (int c = 6; c <= 15; c++) step(4'(c));
    step(4'd0);
    chk("t2_wrap_latency", evt_valid, 1);
    chk("t2_wrap_data", evt_data, {8'd16, 4'd0, 3'b001});
    step(4'd0);
    chk("t2_nrec", q.size(), 2);
    d = q[1][14:7] - q[0][14:7];
    chk("t2_ts_delta", d, 11);
    chk("t2_level", evt_level, 0);

    // Count down across zero.
    q.delete();
    counter = 1'b0;
    step(4'd2); step(4'd1); step(4'd0);
    ets.delete(); ets.push_back({cyc, 4'd15, 3'b010});
    step(4'd15);
    step(4'd15);
    chk("t3_nrec", q.size(), 1);
    chk("t3_rec", q[0], ets[0]);

    // Wrap-up landing on thresh=0: one record, both flags.
    q.delete(); ets.delete();
    thresh = 4'd0; counter = 1'b1;
    step(4'd14); step(4'd15);
    ets.push_back({cyc, 4'd0, 3'b101});
    step(4'd0);
    step(4'd0);
    chk("t4_nrec", q.size(), 1);
    chk("t4_rec", q[0], ets[0]);

    // Nine events into a stalled FIFO: eight kept, one dropped.
    q.delete(); ets.delete();
    evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(4'd1);
      ets.push_back({cyc, 4'd0, 3'b100});
      step(4'd0);
      if (i == 7) begin
        chk("t5_level8", evt_level, 8);
        chk("t5_ovf_before", overflow, 0);
      end
    end
    chk("t5_level_full", evt_level, 8);
    chk("t5_ovf", overflow, 1);
`ifdef EVT_DROP_CNT_EN
    chk("t5_drop", drop_cnt, 1);
`endif
    chk("t5_stall_data", evt_data, ets[0]);
    evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) step(4'd0);
    chk("t5_nrec", q.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t5_rec%0d", i), q[i], ets[i]);
    chk("t5_level0", evt_level, 0);

    // Async reset mid-stream with records queued.
    evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin step(4'd1); step(4'd0); end
    chk("t1_pre_level", evt_level, 3);
    #2 reset = 1'b1;
    #1;
    chk("t1_async_valid", evt_valid, 0);
    chk("t1_async_level", evt_level, 0);
    chk("t1_async_ovf",   overflow,  0);
    chk("t1_async_data",  evt_data,  0);
`ifdef EVT_DROP_CNT_EN
    chk("t1_async_drop",  drop_cnt,  0);
`endif
    release_reset();
    step(4'd0);   // count==thresh on first sample: prev not yet valid
    chk("t1_first_sample", evt_valid, 0);
    step(4'd0);
    chk("t1_second_sample", evt_valid, 0);

    // Full FIFO with an event on the same edge as a pop.
    q.delete(); ets.delete();
    for (int i = 0; i < 8; i++) begin
      step(4'd1);
      ets.push_back({cyc, 4'd0, 3'b100});
      step(4'd0);
    end
    step(4'd1);
    chk("t6_full", evt_level, 8);
    evt_ready = 1'b1;
    ets.push_back({cyc, 4'd0, 3'b100});
    step(4'd0);
    chk("t6_level_stays", evt_level, 8);
    chk("t6_no_ovf", overflow, 0);
`ifdef EVT_DROP_CNT_EN
    chk("t6_no_drop", drop_cnt, 0);
`endif
    for (int i = 0; i < 10; i++) step(4'd0);
    chk("t6_nrec", q.size(), 9);
    for (int i = 0; i < 9; i++) chk($sformatf("t6_rec%0d", i), q[i], ets[i]);
    chk("t6_level0", evt_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
